laser_ctrl: RTL and testbench
=============================

LASER_CTRL -- requirements
Module: laser_ctrl

Interface
REQ-001 FIRE_FRAMES, default 8: number of frame_tick pulses the laser stays active per shot; legal range 1..255.
REQ-002 COOLDOWN_FRAMES, default 16: number of frame_tick pulses of lockout after a shot; legal range 1..255.
REQ-003 R_MAX, default 15: laser_r value used when no target is present.
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 frame_tick  input  1  one-cycle pulse, once per VGA frame.
REQ-007 fire  input  1  debounced fire button level.
REQ-008 player_quadrant  input  2  quadrant the player currently faces.
REQ-009 target_r  input  4  radius of the nearest enemy in player_quadrant.
REQ-010 target_valid  input  1  target_r is meaningful.
REQ-011 laser_active  output  1  drives the laser layer enable.
REQ-012 laser_r  output  4  laser end radius; the layer computes end_y = 400 - laser_r*15.
REQ-013 laser_quadrant  output  2  quadrant in which the laser is drawn.
REQ-014 hit_pulse  output  1  one-cycle pulse that reports a shot on a valid target.
REQ-015 busy  output  1  high while the FSM is in FIRING or COOLDOWN.

Function
REQ-016 The FSM SHALL have three states: IDLE, FIRING and COOLDOWN.
REQ-017 A trigger SHALL be a rising edge of fire (fire high and fire_q low); fire_q is a flop that samples fire every cycle.
REQ-018 On a trigger in IDLE, the capture cycle SHALL do all of the following:
- latch laser_quadrant = player_quadrant;
- latch laser_r = target_r if target_valid, else R_MAX;
- pulse hit_pulse iff target_valid;
- move to FIRING.
REQ-019 laser_active and busy SHALL go high on the clock edge that ends the capture cycle (one-cycle latency from trigger to laser visible).
REQ-020 In FIRING, an 8-bit counter SHALL count frame_tick pulses; on the FIRE_FRAMES-th pulse the FSM SHALL enter COOLDOWN and laser_active SHALL fall on that same edge.
REQ-021 In COOLDOWN, the same counter (cleared on entry) SHALL count frame_tick pulses; on the COOLDOWN_FRAMES-th pulse the FSM SHALL enter IDLE and busy SHALL fall.
REQ-022 Triggers in FIRING or COOLDOWN SHALL be discarded; they are not queued.
REQ-023 A frame_tick in the capture cycle SHALL NOT count toward FIRE_FRAMES.
REQ-024 Returning to IDLE and receiving a trigger in the same cycle: the trigger SHALL be ignored, because the state is not yet IDLE.
REQ-025 laser_r and laser_quadrant SHALL hold their latched values through FIRING, COOLDOWN and IDLE until the next capture.
REQ-026 Changes on player_quadrant and target_* after capture SHALL NOT affect the outputs.
REQ-027 hit_pulse SHALL be exactly one cycle wide per qualifying shot.

Reset
REQ-028 While rst_n is low, the block SHALL hold state IDLE, the counter at 0, fire_q at 0, and laser_active, busy, hit_pulse, laser_r and laser_quadrant at 0.
REQ-029 Reset asserted mid-shot SHALL drop laser_active immediately (asynchronously), with no cooldown after release.
REQ-030 After rst_n deasserts, a fire level that is already high SHALL NOT trigger until it is released and pressed again, unless LASER_AUTOFIRE_EN is defined.

Configuration
REQ-031 Macro LASER_AUTOFIRE_EN:
- when defined, the trigger SHALL be the fire level, so a held button re-fires on the first cycle back in IDLE;
- when undefined, the trigger SHALL be the rising edge per REQ-017.

Verification
REQ-032 Press with target_valid=1, target_r=5, player_quadrant=2: expect hit_pulse for 1 cycle, laser_r=5, laser_quadrant=2, laser_active high for exactly 8 frame_ticks, then busy high for a further 16.
REQ-033 Press with target_valid=0: expect laser_r=15, hit_pulse stays 0.
REQ-034 Re-press during FIRING and again during COOLDOWN: expect no change to the outputs and no extended timing.
REQ-035 Fire edge coincident with frame_tick in IDLE: expect laser_active to span 8 further ticks, not 7.
REQ-036 Assert rst_n low at FIRING tick 3: expect all outputs 0 at once; after release with fire held, expect no shot (edge mode) or a shot (LASER_AUTOFIRE_EN).
REQ-037 Hold fire for 100 frames with LASER_AUTOFIRE_EN defined: expect shots starting every 24 frames plus one cycle; undefined: expect exactly one shot.

Source files
------------

// File: rtl/laser_ctrl.sv
// Laser shot controller: captures target on a fire trigger, holds the beam for
// FIRE_FRAMES frames, then locks out for COOLDOWN_FRAMES frames. Macro LASER_AUTOFIRE_EN.
module laser_ctrl #(
  parameter int unsigned FIRE_FRAMES     = 8,
  parameter int unsigned COOLDOWN_FRAMES = 16,
  parameter int unsigned R_MAX           = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [1:0] player_quadrant,
  input  logic [3:0] target_r,
  input  logic       target_valid,
  output logic       laser_active,
  output logic [3:0] laser_r,
  output logic [1:0] laser_quadrant,
  output logic       hit_pulse,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FIRING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  localparam logic [7:0] FIRE_LAST = 8'(FIRE_FRAMES - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [3:0] R_NONE    = 4'(R_MAX);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_fire_q;
  logic       r_armed;
  logic       r_active;
  logic       r_busy;
  logic       r_hit;
  logic [3:0] r_laser_r;
  logic [1:0] r_quad;
  logic       w_trigger;

  // r_armed blocks a button that was already held when reset was released.
`ifdef LASER_AUTOFIRE_EN
  assign w_trigger = fire | (r_fire_q & r_armed & 1'b0);
`else
  assign w_trigger = fire & ~r_fire_q & r_armed;
`endif

  // Shot sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_fire_q  <= 1'b0;
      r_armed   <= 1'b0;
      r_active  <= 1'b0;
      r_busy    <= 1'b0;
      r_hit     <= 1'b0;
      r_laser_r <= 4'd0;
      r_quad    <= 2'd0;
    end else begin
      r_fire_q <= fire;
      r_armed  <= r_armed | ~fire;
      r_hit    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state   <= S_FIRING;
            r_cnt     <= 8'd0;
            r_active  <= 1'b1;
            r_busy    <= 1'b1;
            r_hit     <= target_valid;
            r_laser_r <= target_valid ? target_r : R_NONE;
            r_quad    <= player_quadrant;
          end else begin
            r_cnt <= 8'd0;
          end
        end
        S_FIRING: begin
          if (frame_tick) begin
            if (r_cnt == FIRE_LAST) begin
              r_state  <= S_COOLDOWN;
              r_cnt    <= 8'd0;
              r_active <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        S_COOLDOWN: begin
          if (frame_tick) begin
            if (r_cnt == COOL_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= 8'd0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= 8'd0;
          r_active <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign laser_active   = r_active;
  assign busy           = r_busy;
  assign hit_pulse      = r_hit;
  assign laser_r        = r_laser_r;
  assign laser_quadrant = r_quad;

endmodule

// File: tb/tb_laser_ctrl.sv
// Directed self-checking bench for laser_ctrl; expectations follow LASER_AUTOFIRE_EN.
module tb_laser_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       fire;
  logic [1:0] player_quadrant;
  logic [3:0] target_r;
  logic       target_valid;
  logic       laser_active;
  logic [3:0] laser_r;
  logic [1:0] laser_quadrant;
  logic       hit_pulse;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  logic prev_active = 1'b0;

  laser_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_tick      (frame_tick),
    .fire            (fire),
    .player_quadrant (player_quadrant),
    .target_r        (target_r),
    .target_valid    (target_valid),
    .laser_active    (laser_active),
    .laser_r         (laser_r),
    .laser_quadrant  (laser_quadrant),
    .hit_pulse       (hit_pulse),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (laser_active === 1'b1 && prev_active !== 1'b1) rises = rises + 1;
    prev_active = laser_active;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks_while_active(output int n);
    n = 0;
    while (laser_active === 1'b1 && n < 300) begin
      pulse_tick();
      n++;
    end
  endtask

  task automatic ticks_while_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      pulse_tick();
      n++;
    end
  endtask

  task automatic press(input logic valid, input logic [3:0] r, input logic [1:0] q);
    fire = 1'b0;
    cyc();
    target_valid    = valid;
    target_r        = r;
    player_quadrant = q;
    fire            = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fire = 1'b0; frame_tick = 1'b0;
    target_valid = 1'b0; target_r = 4'd0; player_quadrant = 2'd0;
    cyc(); cyc();
    checks++;
    if ({laser_active, busy, hit_pulse, laser_r, laser_quadrant} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {laser_active, busy, hit_pulse, laser_r, laser_quadrant});
    end
    rst_n = 1'b1;
    cyc(); cyc();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_hit_shot();
    int n;
    press(1'b1, 4'd5, 2'd2);
    checks++;
    if ({laser_active, busy, hit_pulse} !== 3'b111) begin
      failures++; $display("FAIL hit_capture act/busy/hit=%b want=111", {laser_active, busy, hit_pulse});
    end
    checks++;
    if (laser_r !== 4'd5 || laser_quadrant !== 2'd2) begin
      failures++; $display("FAIL hit_latch r=%0d q=%0d want r=5 q=2", laser_r, laser_quadrant);
    end
    fire = 1'b0; target_r = 4'd9; player_quadrant = 2'd1; target_valid = 1'b0;
    cyc();
    checks++;
    if (hit_pulse !== 1'b0) begin failures++; $display("FAIL hit_width hit=%b want=0", hit_pulse); end
    ticks_while_active(n);
    checks++;
    if (n != 8) begin failures++; $display("FAIL hit_fire_frames got=%0d want=8", n); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL hit_cool_busy busy=%b want=1", busy); end
    ticks_while_busy(n);
    checks++;
    if (n != 16) begin failures++; $display("FAIL hit_cool_frames got=%0d want=16", n); end
    checks++;
    if (laser_r !== 4'd5 || laser_quadrant !== 2'd2) begin
      failures++; $display("FAIL hit_hold r=%0d q=%0d want r=5 q=2", laser_r, laser_quadrant);
    end
  endtask

  task automatic test_no_target();
    int n;
    press(1'b0, 4'd7, 2'd3);
    checks++;
    if (hit_pulse !== 1'b0 || laser_r !== 4'd15 || laser_quadrant !== 2'd3) begin
      failures++; $display("FAIL miss_capture hit=%b r=%0d q=%0d want hit=0 r=15 q=3", hit_pulse, laser_r, laser_quadrant);
    end
    fire = 1'b0;
    cyc();
    checks++;
    if (hit_pulse !== 1'b0) begin failures++; $display("FAIL miss_hit hit=%b want=0", hit_pulse); end
    ticks_while_active(n);
    ticks_while_busy(n);
  endtask

  task automatic test_back_to_back();
    int n;
    press(1'b1, 4'd3, 2'd1);
    fire = 1'b0;
    cyc();
    repeat (3) pulse_tick();
    target_r = 4'd12; player_quadrant = 2'd0;
    fire = 1'b1; cyc(); fire = 1'b0; cyc();
    checks++;
    if (hit_pulse !== 1'b0 || laser_r !== 4'd3 || laser_quadrant !== 2'd1) begin
      failures++; $display("FAIL refire_firing hit=%b r=%0d q=%0d want 0/3/1", hit_pulse, laser_r, laser_quadrant);
    end
    ticks_while_active(n);
    checks++;
    if (n != 5) begin failures++; $display("FAIL refire_fire_left got=%0d want=5", n); end
    repeat (4) pulse_tick();
    fire = 1'b1; cyc(); fire = 1'b0; cyc();
    checks++;
    if (laser_active !== 1'b0 || hit_pulse !== 1'b0) begin
      failures++; $display("FAIL refire_cool act=%b hit=%b want 0/0", laser_active, hit_pulse);
    end
    ticks_while_busy(n);
    checks++;
    if (n != 12) begin failures++; $display("FAIL refire_cool_left got=%0d want=12", n); end
  endtask

  task automatic test_tick_coincident();
    int n;
    fire = 1'b0;
    cyc();
    target_valid = 1'b1; target_r = 4'd8; player_quadrant = 2'd0;
    fire = 1'b1; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0; fire = 1'b0;
    checks++;
    if (laser_active !== 1'b1) begin failures++; $display("FAIL coinc_capture act=%b want=1", laser_active); end
    ticks_while_active(n);
    checks++;
    if (n != 8) begin failures++; $display("FAIL coinc_fire_frames got=%0d want=8", n); end
    ticks_while_busy(n);
  endtask

  task automatic test_reset_midshot();
    int n;
    press(1'b1, 4'd6, 2'd3);
    repeat (2) pulse_tick();
    frame_tick = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({laser_active, busy, hit_pulse, laser_r, laser_quadrant} !== 9'd0) begin
      failures++; $display("FAIL midrst_async got=%b want=0", {laser_active, busy, hit_pulse, laser_r, laser_quadrant});
    end
    cyc();
    frame_tick = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
`ifdef LASER_AUTOFIRE_EN
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midrst_release busy=%b want=1", busy); end
`else
    checks++;
    if (busy !== 1'b0 || laser_active !== 1'b0) begin
      failures++; $display("FAIL midrst_release busy=%b act=%b want 0/0", busy, laser_active);
    end
`endif
    fire = 1'b0;
    cyc();
    ticks_while_active(n);
    ticks_while_busy(n);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_drain busy=%b want=0", busy); end
  endtask

  task automatic test_held_fire();
    int r0;
    fire = 1'b0;
    cyc();
    r0 = rises;
    fire = 1'b1;
    repeat (100) pulse_tick();
    fire = 1'b0;
    cyc();
    checks++;
`ifdef LASER_AUTOFIRE_EN
    if (rises - r0 != 5) begin failures++; $display("FAIL held_shots got=%0d want=5", rises - r0); end
`else
    if (rises - r0 != 1) begin failures++; $display("FAIL held_shots got=%0d want=1", rises - r0); end
`endif
  endtask

  initial begin
    test_reset();
    test_hit_shot();
    test_no_target();
    test_back_to_back();
    test_tick_coincident();
    test_reset_midshot();
    test_held_fire();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
